// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: ID/EX-to-MEM handshake bundle for the ALU execute stage
interface alu_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [REG_W-1:0] rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [REG_W-1:0] rd_out;
  logic             overflow;
  modport master (
    output flush, in_valid, alu_control, operand_a, operand_b, rd_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, overflow
  );
  modport slave (
    input  flush, in_valid, alu_control, operand_a, operand_b, rd_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, overflow
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: MIPS EX stage ALU with registered output plus skid buffer; define ALU_OVF_EN to store signed overflow
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [REG_W-1:0] rd;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
  } entry_t;
  state_t           state_q, state_d;
  entry_t           out_q, out_d, skid_q, skid_d, new_e;
  logic [WIDTH-1:0] sum, diff, res;
  logic             slt, in_fire, out_fire;
  always_comb begin
    sum  = bus.operand_a + bus.operand_b;
    diff = bus.operand_a - bus.operand_b;
    slt  = $signed(bus.operand_a) < $signed(bus.operand_b);
    res  = bus.alu_control == 3'd0 ? sum :
           bus.alu_control == 3'd1 ? diff :
           bus.alu_control == 3'd2 ? bus.operand_a & bus.operand_b :
           bus.alu_control == 3'd3 ? bus.operand_a | bus.operand_b :
           bus.alu_control == 3'd4 ? ~(bus.operand_a | bus.operand_b) :
           bus.alu_control == 3'd5 ? {{(WIDTH-1){1'b0}}, slt} : '0;
    new_e      = '0;
    new_e.res  = res;
    new_e.zero = res == '0;
    new_e.rd   = bus.rd_in;
`ifdef ALU_OVF_EN
    new_e.ovf  = (bus.alu_control == 3'd0 && bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1] &&
                  sum[WIDTH-1] != bus.operand_a[WIDTH-1]) ||
                 (bus.alu_control == 3'd1 && bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1] &&
                  diff[WIDTH-1] != bus.operand_a[WIDTH-1]);
`endif
  end
  assign bus.in_ready  = state_q != FULL;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.result    = out_q.res;
  assign bus.zero      = out_q.zero;
  assign bus.rd_out    = out_q.rd;
`ifdef ALU_OVF_EN
  assign bus.overflow  = out_q.ovf;
`else
  assign bus.overflow  = 1'b0;
`endif
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        out_d   = new_e;
        state_d = ONE;
      end
      ONE: if (in_fire && out_fire) begin
        out_d = new_e;
      end else if (in_fire) begin
        skid_d  = new_e;
        state_d = FULL;
      end else if (out_fire) begin
        state_d = EMPTY;
      end
      FULL: if (out_fire) begin
        out_d   = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table plus stall, flush and async-reset sequences
module tb_alu_exec_stage;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        z;
    logic        ovf;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t v[12];
  alu_exec_stage_if #(.WIDTH(32), .REG_W(5)) bif ();
  alu_exec_stage #(.WIDTH(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bif.in_valid    = 1;
    bif.alu_control = op;
    bif.operand_a   = a;
    bif.operand_b   = b;
    bif.rd_in       = rd;
  endtask
  task automatic chk_out(input string tag, input logic [31:0] res, input logic z, input logic [4:0] rd, input logic ovf);
    logic e_ovf;
`ifdef ALU_OVF_EN
    e_ovf = ovf;
`else
    e_ovf = 1'b0;
`endif
    chk({tag, ".out_valid"}, 32'(bif.out_valid), 32'd1);
    chk({tag, ".result"}, bif.result, res);
    chk({tag, ".zero"}, 32'(bif.zero), 32'(z));
    chk({tag, ".rd_out"}, 32'(bif.rd_out), 32'(rd));
    chk({tag, ".overflow"}, 32'(bif.overflow), 32'(e_ovf));
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, 32'(bif.out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(bif.in_ready), 32'd1);
  endtask
  initial begin
    v[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1'b1};
    v[1]  = '{3'd1, 32'h00000005, 32'h00000005, 5'd2,  32'h00000000, 1'b1, 1'b0};
    v[2]  = '{3'd5, 32'hFFFFFFFF, 32'h00000001, 5'd3,  32'h00000001, 1'b0, 1'b0};
    v[3]  = '{3'd4, 32'h00000000, 32'h00000000, 5'd4,  32'hFFFFFFFF, 1'b0, 1'b0};
    v[4]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5,  32'h00F000F0, 1'b0, 1'b0};
    v[5]  = '{3'd6, 32'h00000012, 32'h00000034, 5'd6,  32'h00000000, 1'b1, 1'b0};
    v[6]  = '{3'd3, 32'h0000FF00, 32'h00FF0000, 5'd7,  32'h00FFFF00, 1'b0, 1'b0};
    v[7]  = '{3'd1, 32'h80000000, 32'h00000001, 5'd8,  32'h7FFFFFFF, 1'b0, 1'b1};
    v[8]  = '{3'd5, 32'h00000001, 32'hFFFFFFFF, 5'd9,  32'h00000000, 1'b1, 1'b0};
    v[9]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 5'd10, 32'h00000000, 1'b1, 1'b0};
    v[10] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1'b1, 1'b0};
    v[11] = '{3'd1, 32'h00000003, 32'h00000005, 5'd12, 32'hFFFFFFFE, 1'b0, 1'b0};
    bif.flush = 0;
    bif.in_valid = 0;
    bif.out_ready = 1;
    drive(3'd0, 0, 0, 0);
    bif.in_valid = 0;
    #12;
    chk_idle("reset");
    chk("reset.result", bif.result, 32'd0);
    chk("reset.zero", 32'(bif.zero), 32'd0);
    #4 rst_n = 1;
    tick();
    // Back-to-back stream with out_ready high: each entry visible exactly one cycle later
    for (int i = 0; i < 12; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].rd);
      tick();
      chk_out($sformatf("vec%0d", i), v[i].res, v[i].z, v[i].rd, v[i].ovf);
    end
    bif.in_valid = 0;
    tick();
    chk_idle("drain");
    bif.out_ready = 0;
    drive(3'd0, 1, 2, 5'd1);
    tick();
    chk("stall.in_ready_one", 32'(bif.in_ready), 32'd1);
    drive(3'd0, 3, 4, 5'd2);
    tick();
    chk("stall.in_ready_full", 32'(bif.in_ready), 32'd0);
    chk_out("stall.holdA", 32'd3, 1'b0, 5'd1, 1'b0);
    drive(3'd0, 5, 6, 5'd3);
    tick();
    tick();
    chk_out("stall.stillA", 32'd3, 1'b0, 5'd1, 1'b0);
    chk("stall.in_ready_held", 32'(bif.in_ready), 32'd0);
    bif.out_ready = 1;
    tick();
    chk_out("stall.B", 32'd7, 1'b0, 5'd2, 1'b0);
    chk("stall.in_ready_back", 32'(bif.in_ready), 32'd1);
    tick();
    bif.in_valid = 0;
    chk_out("stall.C", 32'd11, 1'b0, 5'd3, 1'b0);
    tick();
    chk_idle("stall.empty");
    bif.out_ready = 0;
    drive(3'd2, 32'hFF, 32'h0F, 5'd4);
    tick();
    drive(3'd3, 32'hF0, 32'h0F, 5'd5);
    tick();
    chk("flush.full", 32'(bif.in_ready), 32'd0);
    bif.flush = 1;
    drive(3'd0, 9, 9, 5'd6);
    tick();
    bif.flush = 0;
    bif.in_valid = 0;
    chk_idle("flush");
    tick();
    chk_idle("flush.dropped");
    drive(3'd0, 32'h7FFFFFFF, 32'h1, 5'd7);
    tick();
    drive(3'd4, 0, 0, 5'd8);
    tick();
    bif.in_valid = 0;
    chk_out("arst.before", 32'h80000000, 1'b0, 5'd7, 1'b1);
    #2 rst_n = 0;
    #1;
    chk_idle("arst");
    chk("arst.result", bif.result, 32'd0);
    chk("arst.rd_out", 32'(bif.rd_out), 32'd0);
    chk("arst.overflow", 32'(bif.overflow), 32'd0);
    #3 rst_n = 1;
    bif.out_ready = 1;
    tick();
    chk_idle("arst.after");
    drive(3'd1, 10, 4, 5'd9);
    tick();
    bif.in_valid = 0;
    chk_out("arst.resume", 32'd6, 1'b0, 5'd9, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
